// File: rtl/bit_count_ud_n_pkg.sv
// Shared constants for the bit_count_ud_n up/down counter.
//   DIR_UP / DIR_DN : encodings of the direction input x
//   MODE_WRAP / MODE_SAT : values of the SAT parameter
package bit_count_ud_n_pkg;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DN    = 1'b1;
    localparam int   MODE_WRAP = 0;
    localparam int   MODE_SAT  = 1;

endpackage

// File: rtl/bit_count_ud_n_dff_n.sv
// dff_n: WIDTH-bit D register with synchronous active-high reset to RST_VAL.
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : synchronous reset, active high
//   i_d     : next value
//   o_q     : registered value
module dff_n #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_q <= RST_VAL;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/bit_count_ud_n.sv
// bit_count_ud_n: parametrised WIDTH-bit synchronous up/down counter with
// count enable, parallel load, wrap or saturate boundary behaviour, a
// combinational lookahead flag and a registered wrap/limit pulse.
// Ports:
//   clk     : clock, rising edge
//   reset   : synchronous reset, active high (q<=RST_VAL, wrap<=0, ovf<=0)
//   en      : count enable
//   x       : direction, 0 = up, 1 = down
//   load    : parallel load request (beats en)
//   d       : load value
//   q       : counter state
//   l       : next counting step reaches the boundary (combinational)
//   wrap    : one-cycle pulse, boundary crossed (SAT=0) or blocked (SAT=1)
//   clr_ovf : clears ovf              (only with OVF_STICKY_EN)
//   ovf     : sticky wrap indicator   (only with OVF_STICKY_EN)
// Configuration macro: OVF_STICKY_EN adds clr_ovf/ovf and the sticky register.
module bit_count_ud_n
    import bit_count_ud_n_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               SAT     = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             x,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             l,
`ifdef OVF_STICKY_EN
    input  logic             clr_ovf,
    output logic             ovf,
`endif
    output logic             wrap
);

    localparam logic [WIDTH-1:0] W_MAX    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] W_MAX_M1 = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic [WIDTH-1:0] W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] W_ZERO   = '0;

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_q_next;
    logic             w_wrap_next;
    logic             r_wrap;

    dff_n #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
    ) u_q_reg (
        .i_clk   (clk),
        .i_reset (reset),
        .i_d     (w_q_next),
        .o_q     (w_q)
    );

    // Next state: load beats counting; reset is applied inside the register.
    always_comb begin
        w_q_next    = w_q;
        w_wrap_next = 1'b0;
        if (load) begin
            w_q_next = d;
        end else if (en) begin
            if (x == DIR_UP) begin
                if (w_q == W_MAX) begin
                    w_wrap_next = 1'b1;
                    w_q_next    = (SAT == MODE_SAT) ? w_q : W_ZERO;
                end else begin
                    w_q_next = w_q + W_ONE;
                end
            end else begin
                if (w_q == W_ZERO) begin
                    w_wrap_next = 1'b1;
                    w_q_next    = (SAT == MODE_SAT) ? w_q : W_MAX;
                end else begin
                    w_q_next = w_q - W_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap_next;
        end
    end

`ifdef OVF_STICKY_EN
    logic r_ovf;

    // A wrap event in the same cycle as clr_ovf keeps ovf set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_wrap_next) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    assign ovf = r_ovf;
`endif

    // Lookahead: one counting step away from the boundary in the current direction.
    assign l = en & ~load & (((x == DIR_UP) & (w_q == W_MAX_M1)) |
                             ((x == DIR_DN) & (w_q == W_ONE)));

    assign q    = w_q;
    assign wrap = r_wrap;

endmodule
